// File: rtl/upd4990_pkg.sv
// Shared constants for the uPD4990 host-side serial master.
// Command codes, time-word field offsets and the read-sequence step type.
package upd4990_pkg;

  localparam logic [3:0] CMD_HOLD    = 4'b0000;
  localparam logic [3:0] CMD_SHIFT   = 4'b0001;
  localparam logic [3:0] CMD_SET     = 4'b0010;
  localparam logic [3:0] CMD_READ    = 4'b0011;
  localparam logic [3:0] CMD_TP64    = 4'b0100;
  localparam logic [3:0] CMD_IRQ_RST = 4'b1100;

  localparam int SEC_LSB   = 0;
  localparam int MIN_LSB   = 8;
  localparam int HOUR_LSB  = 16;
  localparam int DAY_LSB   = 24;
  localparam int WDAY_LSB  = 32;
  localparam int MONTH_LSB = 36;
  localparam int YEAR_LSB  = 40;

  typedef enum logic [1:0] {
    STEP_LOAD,
    STEP_SHIFT,
    STEP_READ,
    STEP_HOLD
  } step_e;

endpackage

// File: rtl/upd4990_bit_timer.sv
// Half-phase timer shared by frame and read states.
// Emits a tick on the last cycle of each half-phase and tracks low/high.
module upd4990_bit_timer #(
  parameter int CLK_DIV = 8
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic run,
  output logic tick,
  output logic hi
);

  logic [7:0] phase;

  assign tick = run && (phase == 8'(CLK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      phase <= 8'd0;
      hi    <= 1'b0;
    end else if (!run) begin
      phase <= 8'd0;
      hi    <= 1'b0;
    end else if (tick) begin
      phase <= 8'd0;
      hi    <= ~hi;
    end else begin
      phase <= phase + 8'd1;
    end
  end

endmodule

// File: rtl/upd4990_host.sv
// Host-side serial master for the uPD4990 RTC: command frames,
// 48-bit time read-out and TP rising-edge detection.
module upd4990_host
  import upd4990_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        REQ,
  input  logic        REQ_READ,
  input  logic [3:0]  REQ_CMD,
  output logic        BUSY,
  output logic        DONE,
  output logic [47:0] TIME_OUT,
  output logic        CS,
  output logic        OE,
  output logic        DATA_CLK,
  output logic        DATA_IN,
  output logic        STROBE,
  input  logic        DATA_OUT,
  input  logic        TP,
  output logic        TP_RISE
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BIT_LO  = 3'd1;
  localparam logic [2:0] S_BIT_HI  = 3'd2;
  localparam logic [2:0] S_STB_HI  = 3'd3;
  localparam logic [2:0] S_STB_GAP = 3'd4;
  localparam logic [2:0] S_RD_LO   = 3'd5;
  localparam logic [2:0] S_RD_HI   = 3'd6;
  localparam logic [2:0] S_FINISH  = 3'd7;

  logic [2:0]  state;
  step_e       step;
  logic [5:0]  bitcnt;
  logic        is_read;
  logic [3:0]  cmd_lat;
  logic [3:0]  cur_cmd;
  logic [47:0] shadow;
  logic [47:0] time_q;
  logic        run;
  logic        tick;
  logic        hi;
  logic        dout_s1;
  logic        dout_s2;
  logic        tp_s1;
  logic        tp_s2;
  logic        tp_s3;
  logic        tp_rise_q;

  assign run = (state != S_IDLE) && (state != S_FINISH);

  upd4990_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .CLK(CLK),
    .nRESET(nRESET),
    .run(run),
    .tick(tick),
    .hi(hi)
  );

  always_comb begin
    cur_cmd = CMD_HOLD;
    unique case (1'b1)
      !is_read:                        cur_cmd = cmd_lat;
      is_read && step == STEP_LOAD:    cur_cmd = CMD_READ;
      is_read && step == STEP_SHIFT:   cur_cmd = CMD_SHIFT;
      default:                         cur_cmd = CMD_HOLD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      dout_s1   <= 1'b0;
      dout_s2   <= 1'b0;
      tp_s1     <= 1'b0;
      tp_s2     <= 1'b0;
      tp_s3     <= 1'b0;
      tp_rise_q <= 1'b0;
    end else begin
      dout_s1   <= DATA_OUT;
      dout_s2   <= dout_s1;
      tp_s1     <= TP;
      tp_s2     <= tp_s1;
      tp_s3     <= tp_s2;
      tp_rise_q <= tp_s2 & ~tp_s3;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state   <= S_IDLE;
      step    <= STEP_LOAD;
      bitcnt  <= 6'd0;
      is_read <= 1'b0;
      cmd_lat <= 4'd0;
      shadow  <= 48'd0;
      time_q  <= 48'd0;
    end else begin
      unique case (state)
        S_IDLE, S_FINISH: begin
          if (REQ) begin
            state   <= S_BIT_LO;
            step    <= STEP_LOAD;
            bitcnt  <= 6'd0;
            is_read <= REQ_READ;
            cmd_lat <= REQ_CMD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BIT_LO: if (tick) state <= S_BIT_HI;
        S_BIT_HI: begin
          if (tick) begin
            if (bitcnt == 6'd3) begin
              bitcnt <= 6'd0;
              state  <= S_STB_HI;
            end else begin
              bitcnt <= bitcnt + 6'd1;
              state  <= S_BIT_LO;
            end
          end
        end
        S_STB_HI: if (tick) state <= S_STB_GAP;
        S_STB_GAP: begin
          if (tick) begin
            if (!is_read || step == STEP_HOLD) begin
              state <= S_FINISH;
              // publish the whole word at once, with DONE
              if (is_read) time_q <= shadow;
            end else if (step == STEP_LOAD) begin
              step  <= STEP_SHIFT;
              state <= S_BIT_LO;
            end else begin
              step  <= STEP_READ;
              state <= S_RD_LO;
            end
          end
        end
        S_RD_LO: begin
          if (tick) begin
            shadow <= {dout_s2, shadow[47:1]};
            state  <= S_RD_HI;
          end
        end
        S_RD_HI: begin
          if (tick) begin
            if (bitcnt == 6'd47) begin
              bitcnt <= 6'd0;
              step   <= STEP_HOLD;
              state  <= S_BIT_LO;
            end else begin
              bitcnt <= bitcnt + 6'd1;
              state  <= S_RD_LO;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY     = run;
  assign DONE     = (state == S_FINISH);
  assign TIME_OUT = time_q;
  assign CS       = 1'b1;
  assign OE       = 1'b1;
  assign DATA_CLK = hi && (state == S_BIT_HI || state == S_RD_HI);
  assign DATA_IN  = (state == S_BIT_LO || state == S_BIT_HI)
                    ? cur_cmd[bitcnt[1:0]] : 1'b0;
  assign STROBE   = (state == S_STB_HI);
  assign TP_RISE  = tp_rise_q;

endmodule
